// File: rtl/spike_rate_decoder.sv
// Counts spikes per neuron over window_len enabled samples, then scans for the winner (N cycles).
// Result latency window_len+N edges with enable high; result held until result_ready, start ignored while busy.
module spike_rate_decoder #(
  parameter int N     = 4,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8,
  parameter int IDX_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic [WIN_W-1:0]   window_len,
  input  logic [N-1:0]       spikes_in,
  input  logic               result_ready,
  output logic               result_valid,
  output logic [IDX_W-1:0]   winner,
  output logic [CNT_W-1:0]   winner_count,
  output logic               tie,
  output logic [N*CNT_W-1:0] counts_out,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, COUNT, SCAN, VALID} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] LAST_K  = IDX_W'(N - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt [N];
  logic [WIN_W-1:0] samp, samp_inc, win_len;
  logic [IDX_W-1:0] scan_k;
  logic             accept, close_win, scan_last;

  assign samp_inc  = samp + WIN_W'(1);
  assign accept    = (state == IDLE) && start && (window_len != '0);
  assign close_win = (state == COUNT) && enable && (samp_inc == win_len);
  assign scan_last = (scan_k == LAST_K);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = COUNT;
      end
      COUNT: if (close_win) state_nxt = SCAN;
      SCAN:  if (scan_last) state_nxt = VALID;
      VALID: begin
        result_valid = 1'b1;
        if (result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Spike counters saturate; they are only cleared by an accepted start so the
  // last window's histogram stays visible after the result is consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      samp    <= '0;
      win_len <= '0;
    end else if (accept) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      samp    <= '0;
      win_len <= window_len;
    end else if (state == COUNT && enable) begin
      samp <= samp_inc;
      for (int i = 0; i < N; i++) begin
        if (spikes_in[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_k       <= '0;
      winner       <= '0;
      winner_count <= '0;
      tie          <= 1'b0;
    end else if (accept) begin
      scan_k <= '0;
    end else if (state == SCAN) begin
      scan_k <= scan_last ? '0 : scan_k + IDX_W'(1);
      if (scan_k == '0) begin
        winner       <= '0;
        winner_count <= cnt[0];
        tie          <= 1'b0;
      end else if (cnt[scan_k] > winner_count) begin
        winner       <= scan_k;
        winner_count <= cnt[scan_k];
        tie          <= 1'b0;
      end else if (cnt[scan_k] == winner_count) begin
        tie <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign counts_out[g*CNT_W +: CNT_W] = cnt[g];
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized bench for spike_rate_decoder against a per-window histogram model.
module tb_spike_rate_decoder;

  localparam int N     = 4;
  localparam int CNT_W = 8;
  localparam int WIN_W = 8;
  localparam int IDX_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic               clk, reset, enable, start, result_ready;
  logic [WIN_W-1:0]   window_len;
  logic [N-1:0]       spikes_in;
  logic               result_valid, tie, busy;
  logic [IDX_W-1:0]   winner;
  logic [CNT_W-1:0]   winner_count;
  logic [N*CNT_W-1:0] counts_out;

  spike_rate_decoder #(.N(N), .CNT_W(CNT_W), .WIN_W(WIN_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .window_len(window_len), .spikes_in(spikes_in), .result_ready(result_ready),
    .result_valid(result_valid), .winner(winner), .winner_count(winner_count),
    .tie(tie), .counts_out(counts_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mc [N];
  logic [N-1:0] seq [$];
  int obs_winner, obs_count, obs_tie, obs_lat;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*CNT_W-1:0] pack_counts();
    logic [N*CNT_W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*CNT_W +: CNT_W] = CNT_W'(mc[i]);
    return v;
  endfunction

  // en_mode: 0 always on, 1 toggling 1,0,1.., 2 random. sp_mode: 0 random, 1 fixed pat, 2 from seq.
  task automatic run_window(input int w, input int en_mode, input int sp_mode,
                            input logic [N-1:0] pat, input int hold);
    int samples, edges, waited, maxv, ew, nmax;
    logic en;
    logic [N-1:0] sp;
    start = 1'b1; window_len = WIN_W'(w); spikes_in = N'($urandom);
    enable = 1'b1; result_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) mc[i] = 0;
    check_eq("busy_after_start", busy, 1);
    check_eq("counts_cleared", counts_out, pack_counts());

    samples = 0; edges = 0;
    while (samples < w && edges < 4*w + 40) begin
      case (en_mode)
        0:       en = 1'b1;
        1:       en = (edges % 2 == 0);
        default: en = 1'($urandom_range(0, 1));
      endcase
      case (sp_mode)
        1:       sp = pat;
        2:       sp = (seq.size() > 0) ? seq.pop_front() : '0;
        default: sp = N'($urandom);
      endcase
      enable = en; spikes_in = sp;
      start = ($urandom_range(0, 7) == 0); window_len = WIN_W'($urandom);
      result_ready = 1'($urandom_range(0, 1));
      if (en) begin
        samples++;
        for (int i = 0; i < N; i++) if (sp[i] && mc[i] < CMAX) mc[i]++;
      end
      tick();
      edges++;
      check_eq("counts_live", counts_out, pack_counts());
    end
    start = 1'b0;
    check_eq("busy_scan", busy, 1);
    check_eq("valid_low_scan", result_valid, 0);

    waited = 0;
    while (!result_valid && waited < N + 4) begin
      enable = 1'($urandom_range(0, 1)); spikes_in = N'($urandom);
      result_ready = 1'($urandom_range(0, 1));
      tick();
      waited++;
    end
    result_ready = 1'b0;
    obs_lat = edges + waited;
    check_eq("scan_latency", waited, N);

    maxv = -1; ew = 0; nmax = 0;
    for (int i = 0; i < N; i++) if (mc[i] > maxv) begin maxv = mc[i]; ew = i; end
    for (int i = 0; i < N; i++) if (mc[i] == maxv) nmax++;
    check_eq("valid_high", result_valid, 1);
    check_eq("winner", winner, ew);
    check_eq("winner_count", winner_count, maxv);
    check_eq("tie", tie, (nmax > 1));
    check_eq("counts_hold", counts_out, pack_counts());
    obs_winner = winner; obs_count = winner_count; obs_tie = tie;

    for (int h = 0; h < hold; h++) begin
      start = 1'($urandom_range(0, 1)); window_len = WIN_W'($urandom_range(1, 255));
      enable = 1'($urandom_range(0, 1)); spikes_in = N'($urandom);
      tick();
      check_eq("hold_valid", result_valid, 1);
      check_eq("hold_winner", winner, ew);
      check_eq("hold_count", winner_count, maxv);
      check_eq("hold_tie", tie, (nmax > 1));
      check_eq("hold_counts", counts_out, pack_counts());
    end
    start = 1'b0; result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_eq("valid_drop", result_valid, 0);
    check_eq("busy_drop", busy, 0);
    check_eq("counts_after", counts_out, pack_counts());
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; result_ready = 1'b0;
    window_len = '0; spikes_in = '0;
    #2;
    check_eq("rst_valid", result_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_winner", winner, 0);
    check_eq("rst_count", winner_count, 0);
    check_eq("rst_tie", tie, 0);
    check_eq("rst_counts", counts_out, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check_eq("idle_busy", busy, 0);

    // single hot neuron, enable held high
    run_window(4, 0, 1, 4'b0100, 0);
    check_eq("t1_winner", obs_winner, 2);
    check_eq("t1_count", obs_count, 4);
    check_eq("t1_tie", obs_tie, 0);
    check_eq("t1_latency", obs_lat, 8);

    // two neurons tied
    seq.push_back(4'b0011); seq.push_back(4'b0001); seq.push_back(4'b0010);
    run_window(3, 0, 2, '0, 0);
    check_eq("t2_winner", obs_winner, 0);
    check_eq("t2_count", obs_count, 2);
    check_eq("t2_tie", obs_tie, 1);

    // toggling enable: 5th enabled sample lands on the 9th edge
    run_window(5, 1, 1, 4'b1000, 0);
    check_eq("t3_winner", obs_winner, 3);
    check_eq("t3_count", obs_count, 5);
    check_eq("t3_latency", obs_lat, 9 + N);

    // full-length windows back to back
    run_window(255, 0, 1, 4'b0001, 2);
    check_eq("t4a_count", obs_count, 255);
    run_window(255, 0, 1, 4'b0001, 0);
    check_eq("t4b_count", obs_count, 255);

    // long hold in VALID with start pulses
    run_window(6, 2, 0, '0, 10);

    // all-zero window
    run_window(3, 0, 1, 4'b0000, 1);
    check_eq("t_zero_winner", obs_winner, 0);
    check_eq("t_zero_count", obs_count, 0);
    check_eq("t_zero_tie", obs_tie, 1);

    for (int r = 0; r < 25; r++)
      run_window($urandom_range(1, 20), $urandom_range(0, 2), 0, '0, $urandom_range(0, 5));

    // reset in the middle of a window
    start = 1'b1; window_len = 8'd10; enable = 1'b1; spikes_in = 4'b1111;
    tick();
    start = 1'b0;
    tick(); tick();
    check_eq("mid_counts", counts_out, 32'h02020202);
    reset = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_valid", result_valid, 0);
    check_eq("arst_counts", counts_out, 0);
    check_eq("arst_winner", winner, 0);
    check_eq("arst_count", winner_count, 0);
    check_eq("arst_tie", tie, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_eq("post_rst_busy", busy, 0);

    // zero-length start is ignored
    start = 1'b1; window_len = '0;
    tick();
    start = 1'b0;
    check_eq("zero_len_busy", busy, 0);
    tick();
    check_eq("zero_len_busy2", busy, 0);
    check_eq("zero_len_valid", result_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
